tick_scheduler: RTL and testbench

Schedules movement ticks for a pool of entity slots (missiles, planes) from the six speed pulses produced by the timer cluster. Each slot is assigned a speed pulse and an enable. The block turns pulses into per-slot pending ticks. A round-robin arbiter then hands those ticks, one at a time, to the single shared position-update datapath over a valid/ready handshake.

---
 rtl/tick_scheduler_pkg.sv | 12 +
 rtl/tick_scheduler_rr_arbiter.sv | 31 +++
 rtl/tick_scheduler.sv | 156 +++++++++++++++
 tb/tb_tick_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tick_scheduler_pkg.sv
// Shared types and widths for the tick scheduler and its round-robin arbiter.
package tick_scheduler_pkg;

  localparam int SPEED_W   = 3;
  localparam int OVERRUN_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Combinational round-robin search: first requesting index at or above i_start,
// wrapping around. N must be a power of two so the index wraps naturally.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_start,
  output logic [$clog2(N)-1:0] o_grant,
  output logic                 o_any
);

  localparam int IW = $clog2(N);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = i_start + IW'(k);
      if (!w_found && i_req[w_idx]) begin
        o_grant = w_idx;
        w_found = 1'b1;
      end
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/tick_scheduler.sv
// Turns speed pulses into per-slot pending ticks and hands them out one at a time
// over a valid/ready port. Define TICK_SCHEDULER_OVERRUN_EN to build the overrun counter.
//
// Handshake: a transfer happens at a rising edge where move_valid && move_ready.
// move_valid stays high and move_slot stays fixed until that transfer; move_ready
// is ignored while move_valid is low.
module tick_scheduler
  import tick_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS  = 8,
  parameter int NUM_SPEEDS = 6
) (
  input  logic                         clk100MHz,
  input  logic                         rst,
  input  logic [NUM_SPEEDS-1:0]        speed_pulse,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SLOTS)-1:0] cfg_slot,
  input  logic [SPEED_W-1:0]           cfg_speed,
  input  logic                         cfg_en,
  output logic                         move_valid,
  output logic [$clog2(NUM_SLOTS)-1:0] move_slot,
  input  logic                         move_ready,
  output logic [OVERRUN_W-1:0]         overrun_cnt
);

  localparam int SLOT_W = $clog2(NUM_SLOTS);
  localparam logic [SPEED_W:0] NUM_SPEEDS_L = NUM_SPEEDS[SPEED_W:0];

  logic [SPEED_W-1:0]  r_speed [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] r_en;
  logic [NUM_SLOTS-1:0] r_pending;
  state_t              r_state;
  logic [SLOT_W-1:0]   r_move_slot;
  logic [SLOT_W-1:0]   r_ptr;

  state_t               w_state_nxt;
  logic                 w_load;
  logic [SLOT_W-1:0]    w_winner;
  logic                 w_any;
  logic [7:0]           w_pulse_ext;
  logic [NUM_SLOTS-1:0] w_hit;
  logic [NUM_SLOTS-1:0] w_loaded;
  logic [NUM_SLOTS-1:0] w_pending_nxt;

  // Pad the pulse vector so any 3-bit speed index is in range; unused speeds read 0.
  assign w_pulse_ext = 8'(speed_pulse);

  always_comb begin
    w_hit    = '0;
    w_loaded = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_hit[i]    = r_en[i] && ({1'b0, r_speed[i]} < NUM_SPEEDS_L) &&
                    w_pulse_ext[r_speed[i]];
      w_loaded[i] = w_load && (w_winner == SLOT_W'(i));
    end
  end

  rr_arbiter #(.N(NUM_SLOTS)) u_arb (
    .i_req   (r_pending),
    .i_start (r_ptr),
    .o_grant (w_winner),
    .o_any   (w_any)
  );

  // Disable beats a new hit; a new hit beats the clear caused by loading.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cfg_we && !cfg_en && (cfg_slot == SLOT_W'(i))) begin
        w_pending_nxt[i] = 1'b0;
      end else if (w_hit[i]) begin
        w_pending_nxt[i] = 1'b1;
      end else if (w_loaded[i]) begin
        w_pending_nxt[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (move_ready) begin
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_move_slot <= '0;
      r_ptr       <= '0;
      r_pending   <= '0;
      r_en        <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) r_speed[i] <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (w_load) begin
        r_move_slot <= w_winner;
        r_ptr       <= w_winner + SLOT_W'(1);
      end
      if (cfg_we) begin
        r_speed[cfg_slot] <= cfg_speed;
        r_en[cfg_slot]    <= cfg_en;
      end
    end
  end

  assign move_valid = (r_state == OFFER);
  assign move_slot  = r_move_slot;

`ifdef TICK_SCHEDULER_OVERRUN_EN
  logic [OVERRUN_W-1:0] r_overrun;
  logic [5:0]           w_ovr_num;
  logic [OVERRUN_W:0]   w_ovr_sum;

  // Every slot that loses a tick this cycle adds one to the count.
  always_comb begin
    w_ovr_num = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_ovr_num = w_ovr_num + 6'(w_hit[i] && r_pending[i] && !w_loaded[i]);
    end
    w_ovr_sum = {1'b0, r_overrun} + (OVERRUN_W + 1)'(w_ovr_num);
  end

  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      r_overrun <= '0;
    end else if (w_ovr_sum[OVERRUN_W]) begin
      r_overrun <= '1;
    end else begin
      r_overrun <= w_ovr_sum[OVERRUN_W-1:0];
    end
  end

  assign overrun_cnt = r_overrun;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: stimulus pushes expected grants into a queue,
// a negedge monitor pops and compares on every accepted transfer.
module tb_tick_scheduler;

  localparam int NSL = 8;
  localparam int NSP = 6;
  localparam int SW  = 3;

  logic           clk100MHz = 1'b0;
  logic           rst = 1'b1;
  logic [NSP-1:0] speed_pulse = '0;
  logic           cfg_we = 1'b0;
  logic [SW-1:0]  cfg_slot = '0;
  logic [2:0]     cfg_speed = '0;
  logic           cfg_en = 1'b0;
  logic           move_valid;
  logic [SW-1:0]  move_slot;
  logic           move_ready = 1'b0;
  logic [7:0]     overrun_cnt;

  logic [SW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic          prev_stall = 1'b0;
  logic [SW-1:0] prev_slot = '0;

  tick_scheduler #(.NUM_SLOTS(NSL), .NUM_SPEEDS(NSP)) dut (
    .clk100MHz   (clk100MHz),
    .rst         (rst),
    .speed_pulse (speed_pulse),
    .cfg_we      (cfg_we),
    .cfg_slot    (cfg_slot),
    .cfg_speed   (cfg_speed),
    .cfg_en      (cfg_en),
    .move_valid  (move_valid),
    .move_slot   (move_slot),
    .move_ready  (move_ready),
    .overrun_cnt (overrun_cnt)
  );

  // clock / reset
  always #5 clk100MHz = ~clk100MHz;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk100MHz) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, move_valid}, 32'd1);
        check("hold_slot", {29'd0, move_slot}, {29'd0, prev_slot});
      end
      if (move_valid && move_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_grant: got slot %0d expected none", move_slot);
        end else begin
          check("grant_slot", {29'd0, move_slot}, {29'd0, exp_q.pop_front()});
        end
      end
      prev_stall = move_valid && !move_ready;
      prev_slot  = move_slot;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk100MHz);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    speed_pulse = '0;
    cfg_we = 1'b0;
    move_ready = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic cfg_wr(input int slot, input int speed, input bit en);
    cfg_we    = 1'b1;
    cfg_slot  = SW'(slot);
    cfg_speed = 3'(speed);
    cfg_en    = en;
    step(1);
    cfg_we    = 1'b0;
  endtask

  task automatic pulse(input logic [NSP-1:0] mask);
    speed_pulse = mask;
    step(1);
    speed_pulse = '0;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step(1);
      k++;
    end
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
    step(4);
  endtask

  initial begin
    // reset values and basic latency
    do_reset();
    check("rst_valid", {31'd0, move_valid}, 32'd0);
    check("rst_slot", {29'd0, move_slot}, 32'd0);
    check("rst_overrun", {24'd0, overrun_cnt}, 32'd0);
    cfg_wr(3, 2, 1'b1);
    move_ready = 1'b1;
    exp_q.push_back(3'd3);
    pulse(6'b000100);
    check("lat_t1_valid", {31'd0, move_valid}, 32'd0);
    step(1);
    check("lat_t2_valid", {31'd0, move_valid}, 32'd1);
    check("lat_t2_slot", {29'd0, move_slot}, 32'd3);
    step(1);
    check("lat_t3_valid", {31'd0, move_valid}, 32'd0);
    drain("drain_latency", 10);

    // round robin, two rounds
    do_reset();
    cfg_wr(0, 0, 1'b1);
    cfg_wr(1, 0, 1'b1);
    cfg_wr(5, 0, 1'b1);
    move_ready = 1'b1;
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd5);
    pulse(6'b000001);
    drain("drain_rr1", 10);
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd5);
    pulse(6'b000001);
    drain("drain_rr2", 10);

    // backpressure
    do_reset();
    cfg_wr(0, 0, 1'b1);
    cfg_wr(1, 0, 1'b1);
    cfg_wr(5, 0, 1'b1);
    move_ready = 1'b0;
    exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd5);
    pulse(6'b000001);
    step(1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", {31'd0, move_valid}, 32'd1);
      check("bp_slot", {29'd0, move_slot}, 32'd0);
      step(1);
    end
    move_ready = 1'b1;
    step(1);
    check("bp_b2b_slot1", {29'd0, move_slot}, 32'd1);
    step(1);
    check("bp_b2b_slot5", {29'd0, move_slot}, 32'd5);
    drain("drain_bp", 10);

    // overrun
    do_reset();
    cfg_wr(2, 1, 1'b1);
    move_ready = 1'b0;
    pulse(6'b000010);
    step(3);
    pulse(6'b000010);
    step(2);
    pulse(6'b000010);
    step(2);
`ifdef TICK_SCHEDULER_OVERRUN_EN
    check("overrun_cnt", {24'd0, overrun_cnt}, 32'd1);
`else
    check("overrun_cnt", {24'd0, overrun_cnt}, 32'd0);
`endif
    check("ovr_valid", {31'd0, move_valid}, 32'd1);
    exp_q.push_back(3'd2); exp_q.push_back(3'd2);
    move_ready = 1'b1;
    drain("drain_overrun", 10);

    // disable clears pending; invalid speed never ticks
    do_reset();
    cfg_wr(3, 0, 1'b1);
    cfg_wr(4, 0, 1'b1);
    move_ready = 1'b0;
    pulse(6'b000001);
    step(2);
    check("dis_valid", {31'd0, move_valid}, 32'd1);
    check("dis_slot", {29'd0, move_slot}, 32'd3);
    cfg_wr(4, 0, 1'b0);
    exp_q.push_back(3'd3);
    move_ready = 1'b1;
    drain("drain_disable", 10);
    cfg_wr(3, 0, 1'b0);
    cfg_wr(6, 7, 1'b1);
    pulse(6'b111111);
    step(8);
    check("badspeed_valid", {31'd0, move_valid}, 32'd0);

    // reset mid-offer
    do_reset();
    cfg_wr(1, 0, 1'b1);
    move_ready = 1'b0;
    pulse(6'b000001);
    step(1);
    check("mid_valid_pre", {31'd0, move_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_valid_rst", {31'd0, move_valid}, 32'd0);
    check("mid_slot_rst", {29'd0, move_slot}, 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    move_ready = 1'b1;
    pulse(6'b111111);
    step(10);
    check("post_rst_valid", {31'd0, move_valid}, 32'd0);

    check("final_queue", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
